// File: rtl/controller_decripto.sv
// AES-128 iterative decryption engine: key schedule is expanded once,
// then one inverse round is applied per clock, with per-round debug buses.
module controller_decripto (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] chave,
  input  logic [127:0] cifra,
  output logic [127:0] palavra,
  output logic         done,
  output logic [127:0] auxEstadoEntrada,
  output logic [127:0] auxChaveEntrada,
  output logic [127:0] estadoSaidaAddRoundKey,
  output logic [127:0] estadoSaidaSubBytes,
  output logic [127:0] estadoSaidaShiftRows,
  output logic [127:0] estadoSaidaMixColumns,
  output logic [2:0]   estado
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_KEY   = 3'd1;
  localparam logic [2:0] S_INIT  = 3'd2;
  localparam logic [2:0] S_ROUND = 3'd3;
  localparam logic [2:0] S_FINAL = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  logic [2:0]   fsm, fsm_nxt;
  logic [127:0] st;
  logic [127:0] rkeys [0:10];
  logic [3:0]   cnt;
  logic [127:0] key_nxt, rk, shf, sub, ark, mix;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // a^254 is the multiplicative inverse in GF(2^8), and maps 0 to 0
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] p, r;
    r = 8'h01;
    p = a;
    for (int i = 1; i < 8; i++) begin
      p = gmul(p, p);
      r = gmul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] a, input int n);
    return (a << n) | (a >> (8 - n));
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] b;
    b = ginv(a);
    return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] a);
    logic [7:0] b;
    b = rotl8(a, 1) ^ rotl8(a, 3) ^ rotl8(a, 6) ^ 8'h05;
    return ginv(b);
  endfunction

  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c-r+4)%4)) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int n = 0; n < 16; n++)
      o[127-8*n -: 8] = inv_sbox(s[127-8*n -: 8]);
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = gmul(8'h0e, a0) ^ gmul(8'h0b, a1) ^ gmul(8'h0d, a2) ^ gmul(8'h09, a3);
      o[119-32*c -: 8] = gmul(8'h09, a0) ^ gmul(8'h0e, a1) ^ gmul(8'h0b, a2) ^ gmul(8'h0d, a3);
      o[111-32*c -: 8] = gmul(8'h0d, a0) ^ gmul(8'h09, a1) ^ gmul(8'h0e, a2) ^ gmul(8'h0b, a3);
      o[103-32*c -: 8] = gmul(8'h0b, a0) ^ gmul(8'h0d, a1) ^ gmul(8'h09, a2) ^ gmul(8'h0e, a3);
    end
    return o;
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] i);
    case (i)
      4'd0:    return 8'h01;
      4'd1:    return 8'h02;
      4'd2:    return 8'h04;
      4'd3:    return 8'h08;
      4'd4:    return 8'h10;
      4'd5:    return 8'h20;
      4'd6:    return 8'h40;
      4'd7:    return 8'h80;
      4'd8:    return 8'h1b;
      4'd9:    return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [127:0] expand_key(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3, t, n0, n1, n2, n3;
    w0 = k[127:96];
    w1 = k[95:64];
    w2 = k[63:32];
    w3 = k[31:0];
    t  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])} ^ {rc, 24'h000000};
    n0 = w0 ^ t;
    n1 = w1 ^ n0;
    n2 = w2 ^ n1;
    n3 = w3 ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  always_ff @(posedge clk) begin
    if (rst) fsm <= S_IDLE;
    else     fsm <= fsm_nxt;
  end

  always_comb begin
    fsm_nxt = S_IDLE;
    case (fsm)
      S_IDLE:  fsm_nxt = start ? S_KEY : S_IDLE;
      S_KEY:   fsm_nxt = (cnt == 4'd9) ? S_INIT : S_KEY;
      S_INIT:  fsm_nxt = S_ROUND;
      S_ROUND: fsm_nxt = (cnt == 4'd1) ? S_FINAL : S_ROUND;
      S_FINAL: fsm_nxt = S_DONE;
      S_DONE:  fsm_nxt = start ? S_KEY : S_DONE;
      default: fsm_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    done   = (fsm == S_DONE);
    estado = fsm;
  end

  // cnt is the key index while expanding and the round index while decrypting
  always_ff @(posedge clk) begin
    if (rst) begin
      st      <= '0;
      palavra <= '0;
      cnt     <= '0;
      for (int i = 0; i < 11; i++) rkeys[i] <= '0;
    end else begin
      case (fsm)
        S_IDLE, S_DONE: begin
          if (start) begin
            rkeys[0] <= chave;
            st       <= cifra;
            cnt      <= '0;
          end
        end
        S_KEY: begin
          rkeys[cnt + 4'd1] <= key_nxt;
          cnt               <= (cnt == 4'd9) ? 4'd0 : cnt + 4'd1;
        end
        S_INIT: begin
          st  <= ark;
          cnt <= 4'd9;
        end
        S_ROUND: begin
          st  <= mix;
          cnt <= cnt - 4'd1;
        end
        S_FINAL: begin
          st      <= ark;
          palavra <= ark;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    key_nxt = expand_key(rkeys[cnt], rcon(cnt));
    rk      = rkeys[0];
    case (fsm)
      S_IDLE, S_KEY: rk = key_nxt;
      S_INIT:        rk = rkeys[10];
      S_ROUND:       rk = rkeys[cnt];
      default:       rk = rkeys[0];
    endcase
    shf = inv_shift_rows(st);
    sub = inv_sub_bytes(shf);
    ark = (fsm == S_INIT) ? (st ^ rk) : (sub ^ rk);
    mix = inv_mix_columns(ark);
  end

  assign auxEstadoEntrada       = st;
  assign auxChaveEntrada        = rk;
  assign estadoSaidaShiftRows   = shf;
  assign estadoSaidaSubBytes    = sub;
  assign estadoSaidaAddRoundKey = ark;
  assign estadoSaidaMixColumns  = mix;

endmodule

// File: tb/tb_controller_decripto.sv
// Directed bench for controller_decripto: known-answer vectors, state schedule,
// reset mid-operation and start-handling cases, results checked via a queue.
module tb_controller_decripto;

  logic         clk = 1'b0;
  logic         rst, start;
  logic [127:0] chave, cifra;
  logic [127:0] palavra;
  logic         done;
  logic [127:0] auxEstadoEntrada, auxChaveEntrada, estadoSaidaAddRoundKey;
  logic [127:0] estadoSaidaSubBytes, estadoSaidaShiftRows, estadoSaidaMixColumns;
  logic [2:0]   estado;

  controller_decripto dut (
    .clk(clk), .rst(rst), .start(start), .chave(chave), .cifra(cifra),
    .palavra(palavra), .done(done),
    .auxEstadoEntrada(auxEstadoEntrada), .auxChaveEntrada(auxChaveEntrada),
    .estadoSaidaAddRoundKey(estadoSaidaAddRoundKey),
    .estadoSaidaSubBytes(estadoSaidaSubBytes),
    .estadoSaidaShiftRows(estadoSaidaShiftRows),
    .estadoSaidaMixColumns(estadoSaidaMixColumns),
    .estado(estado)
  );

  always #5 clk = ~clk;

  localparam logic [127:0] KA   = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CA   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PA   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KA10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;
  localparam logic [127:0] SA   = 128'h7ad5fda789ef4e272bca100b3d9ff59f;
  localparam logic [127:0] KB   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CB   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] KB10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] PB   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CC   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  int total = 0;
  int bad   = 0;
  logic [127:0] expq[$];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] sched(input int k);
    if (k <= 9)  return 3'd1;
    if (k == 10) return 3'd2;
    if (k <= 19) return 3'd3;
    if (k == 20) return 3'd4;
    return 3'd5;
  endfunction

  // drive start for 'hold' cycles; returns at the falling edge after the last held edge
  task automatic launch(input logic [127:0] k, input logic [127:0] ct,
                        input logic [127:0] pt, input int hold);
    @(negedge clk);
    chave = k;
    cifra = ct;
    start = 1'b1;
    expq.push_back(pt);
    repeat (hold) @(negedge clk);
    start = 1'b0;
  endtask

  // 'already' = cycles elapsed since the accepting edge
  task automatic wait_done(input string tag, input int already);
    int cyc;
    logic [127:0] exp;
    cyc = already;
    while (done !== 1'b1 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    chk({tag, "_latency"}, 128'(cyc), 128'd21);
    chk({tag, "_done"}, 128'(done), 128'd1);
    exp = (expq.size() > 0) ? expq.pop_front() : 'x;
    chk({tag, "_palavra"}, palavra, exp);
  endtask

  initial begin
    int cyc;
    rst   = 1'b1;
    start = 1'b0;
    chave = '0;
    cifra = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_estado", 128'(estado), 128'd0);
    chk("rst_done", 128'(done), 128'd0);
    chk("rst_palavra", palavra, 128'd0);
    rst = 1'b0;

    // FIPS-197 C.1 vector with the full state schedule
    launch(KA, CA, PA, 1);
    for (int k = 0; k <= 21; k++) begin
      if (k > 0) @(negedge clk);
      chk($sformatf("A_estado_k%0d", k), 128'(estado), 128'(sched(k)));
      if (k == 10) begin
        chk("A_init_key", auxChaveEntrada, KA10);
        chk("A_init_ark", estadoSaidaAddRoundKey, SA);
      end
      if (k == 11) chk("A_state_after_init", auxEstadoEntrada, SA);
      if (k == 20) chk("A_done_early", 128'(done), 128'd0);
    end
    wait_done("A", 21);

    // FIPS-197 appendix B vector, key[10] seen during INIT_ARK
    launch(KB, CB, PB, 1);
    cyc = 0;
    while (estado !== 3'd2 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    chk("B_key10", auxChaveEntrada, KB10);
    wait_done("B", cyc);

    // reset in the middle of key expansion discards the operation
    launch(KA, CA, PA, 1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_estado", 128'(estado), 128'd0);
    chk("midrst_done", 128'(done), 128'd0);
    chk("midrst_palavra", palavra, 128'd0);
    chk("midrst_state", auxEstadoEntrada, 128'd0);
    rst = 1'b0;
    void'(expq.pop_back());
    launch(KA, CA, PA, 1);
    wait_done("after_rst", 0);

    // start pulsed during ROUND with a different ciphertext is ignored
    launch(KB, CB, PB, 1);
    cyc = 0;
    while (estado !== 3'd3 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    start = 1'b1;
    cifra = CA;
    @(negedge clk);
    cyc++;
    start = 1'b0;
    wait_done("ignore", cyc);

    // restart from DONE with a new ciphertext
    launch(KA, CA, PA, 1);
    chk("restart_done_drop", 128'(done), 128'd0);
    chk("restart_estado", 128'(estado), 128'd1);
    wait_done("restart", 0);

    // all-zero key, start held for three cycles gives one operation only
    launch(128'd0, CC, 128'd0, 3);
    wait_done("zero", 2);
    repeat (3) @(negedge clk);
    chk("zero_stays_done", 128'(estado), 128'd5);
    chk("zero_palavra_hold", palavra, 128'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
